// File: rtl/vb_pkg.sv
// -----------------------------------------------------------------------------
// vb_pkg
// Shared definitions for the variable-byte (VB) encoder and its board-level
// sequencer: the sequencer state enumeration, capture-buffer sizing and the
// byte-lane indices of the 32-bit value being encoded.
// -----------------------------------------------------------------------------
package vb_pkg;

    // Sequencer states. Exposed on a debug port so checkers can observe them.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_SHOW    = 2'd3
    } vb_state_t;

    // A 32-bit value carries at most ceil(32/7) = 5 VB bytes.
    localparam int MAX_BYTES = 5;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    // Byte lanes of the 32-bit value; lane 3 holds bits [31:24].
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // Entries arrive MSB first: entry 0 fills lane 3, entry 3 fills lane 0.
    function automatic logic [1:0] entry_lane(input logic [1:0] ei);
        return LANE_B3 - ei;
    endfunction

endpackage

// File: rtl/vb_capture_buf.sv
// -----------------------------------------------------------------------------
// vb_capture_buf
// MAX_BYTES x 8 register file holding the bytes emitted by one encode, plus
// the count of stored bytes.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (clears the count only)
//   clr    synchronous clear of the count (start of a new encode)
//   we     write strobe; stores wdata at waddr and advances the count
//   waddr  write address
//   wdata  write data
//   raddr  asynchronous read address
//   rdata  read data (0 for addresses beyond the buffer)
//   cnt    number of bytes stored since the last clear
//   full   cnt has reached MAX_BYTES; further writes are ignored
// -----------------------------------------------------------------------------
module vb_capture_buf
    import vb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [CNT_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [CNT_W-1:0] raddr,
    output logic [7:0]       rdata,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    logic [7:0] mem [MAX_BYTES];

    assign full = (cnt == MAX_CNT);

    // Storage needs no reset: the sequencer never displays an entry at or
    // beyond cnt.
    always_ff @(posedge clk) begin
        if (we && !full && (waddr < MAX_CNT)) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (we && !full) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign rdata = (raddr < MAX_CNT) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/vb_encode_sequencer.sv
// -----------------------------------------------------------------------------
// vb_encode_sequencer
// Board-level controller for the VB encoder. Four `enter` pulses assemble a
// 32-bit value MSB first from `sw`, one encode is launched, the emitted bytes
// are captured, and `next` then steps through them on the LEDs while the
// 7-segment digit shows the index.
//
// Encoder handshake: `enc_load` is a one-cycle launch pulse issued only while
// `enc_ready` is high; after that every cycle with `enc_valid` high carries one
// byte on `enc_byte` (no back-pressure), and `enc_last` marks the final byte.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sw                  byte to enter
//   enter, next         debounced one-cycle button pulses
//   enc_ready           encoder idle, accepts a load
//   enc_valid/byte/last encoder output byte stream
//   enc_load            launch pulse to the encoder
//   enc_value           value to encode, stable from LAUNCH until SHOW
//   led                 displayed byte
//   digit               7-segment nibble (entry index / byte count / index)
//   busy                high in LAUNCH and WAIT
//   err                 sticky error for the current run (overflow/timeout)
//   dbg_state           current FSM state
// All outputs are registered.
// -----------------------------------------------------------------------------
module vb_encode_sequencer
    import vb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    input  logic        enter,
    input  logic        next,
    input  logic        enc_ready,
    input  logic        enc_valid,
    input  logic [7:0]  enc_byte,
    input  logic        enc_last,
    output logic        enc_load,
    output logic [31:0] enc_value,
    output logic [7:0]  led,
    output logic [3:0]  digit,
    output logic        busy,
    output logic        err,
    output vb_state_t   dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    vb_state_t        state;
    logic [1:0]       ei;
    logic [CNT_W-1:0] si;
    logic [WD_W-1:0]  wd;

    logic             cap_we;
    logic             cap_clr;
    logic [CNT_W-1:0] cap_cnt;
    logic             cap_full;
    logic [CNT_W-1:0] rd_addr;
    logic [7:0]       cap_rdata;
    logic [CNT_W-1:0] si_wrap;

    assign dbg_state = state;

    // A byte arriving when the buffer is already full is dropped.
    assign cap_we  = (state == ST_WAIT) && enc_valid && !cap_full;
    // The count restarts on the launch cycle so stale bytes never show.
    assign cap_clr = (state == ST_LAUNCH) && enc_load;

    assign si_wrap = (si == cap_cnt - 1'b1) ? '0 : si + 1'b1;

    // The read port looks ahead to the byte that led must show next cycle:
    // entry 0 when entering SHOW, the stepped index on a `next`.
    always_comb begin
        rd_addr = '0;
        if (state == ST_SHOW && next && !enter) begin
            rd_addr = si_wrap;
        end
    end

    vb_capture_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (cap_clr),
        .we    (cap_we),
        .waddr (cap_cnt),
        .wdata (enc_byte),
        .raddr (rd_addr),
        .rdata (cap_rdata),
        .cnt   (cap_cnt),
        .full  (cap_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_COLLECT;
            ei        <= '0;
            si        <= '0;
            wd        <= '0;
            enc_load  <= 1'b0;
            enc_value <= '0;
            led       <= '0;
            digit     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    led   <= sw;
                    digit <= 4'(ei);
                    if (enter) begin
                        case (entry_lane(ei))
                            LANE_B3: enc_value[31:24] <= sw;
                            LANE_B2: enc_value[23:16] <= sw;
                            LANE_B1: enc_value[15:8]  <= sw;
                            default: enc_value[7:0]   <= sw;
                        endcase
                        ei    <= ei + 2'd1;
                        digit <= 4'(ei) + 4'd1;
                        if (ei == 2'd3) begin
                            state    <= ST_LAUNCH;
                            led      <= '0;
                            digit    <= '0;
                            busy     <= 1'b1;
                            // Registered launch: fire in the first LAUNCH
                            // cycle when the encoder is already idle.
                            enc_load <= enc_ready;
                        end
                    end
                end

                ST_LAUNCH: begin
                    if (enc_load) begin
                        enc_load <= 1'b0;
                        state    <= ST_WAIT;
                        wd       <= '0;
                    end else if (enc_ready) begin
                        enc_load <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (enc_valid) begin
                        wd <= '0;
                        if (cap_full || enc_last) begin
                            state <= ST_SHOW;
                            busy  <= 1'b0;
                            si    <= '0;
                            digit <= '0;
                            if (cap_full) begin
                                err <= 1'b1;
                            end
                            // A single-byte result is being written this
                            // same edge, so bypass the buffer for it.
                            led <= (cap_cnt == '0) ? enc_byte : cap_rdata;
                        end else begin
                            digit <= 4'(cap_cnt) + 4'd1;
                        end
                    end else if (wd == WD_MAX) begin
                        state <= ST_SHOW;
                        busy  <= 1'b0;
                        si    <= '0;
                        digit <= '0;
                        err   <= 1'b1;
                        led   <= (cap_cnt == '0) ? 8'h00 : cap_rdata;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end

                ST_SHOW: begin
                    if (enter) begin
                        state <= ST_COLLECT;
                        ei    <= '0;
                        err   <= 1'b0;
                        led   <= sw;
                        digit <= '0;
                    end else if (next && cap_cnt != '0) begin
                        si    <= si_wrap;
                        led   <= cap_rdata;
                        digit <= 4'(si_wrap);
                    end
                end

                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_vb_encode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vb_encode_sequencer
// Drives button entries and plays the encoder side, predicting every SHOW
// display (entry and each `next` step) and every launched value from a VB
// reference encoding of the entered value.
// -----------------------------------------------------------------------------
module tb_vb_encode_sequencer;
    import vb_pkg::*;

    localparam int TIMEOUT = 64;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic        enter;
    logic        next;
    logic        enc_ready;
    logic        enc_valid;
    logic [7:0]  enc_byte;
    logic        enc_last;
    logic        enc_load;
    logic [31:0] enc_value;
    logic [7:0]  led;
    logic [3:0]  digit;
    logic        busy;
    logic        err;
    vb_state_t   dbg_state;

    always #5 clk = ~clk;

    vb_encode_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .enter     (enter),
        .next      (next),
        .enc_ready (enc_ready),
        .enc_valid (enc_valid),
        .enc_byte  (enc_byte),
        .enc_last  (enc_last),
        .enc_load  (enc_load),
        .enc_value (enc_value),
        .led       (led),
        .digit     (digit),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] exp_q[$];      // {led, digit, err, busy} per SHOW display
    logic [31:0] exp_val_q[$];  // enc_value at each launch
    logic [7:0]  model_q[$];
    bit          in_show = 1'b0;

    logic      next_seen = 1'b0;
    vb_state_t prev_state = ST_COLLECT;

    always @(posedge clk) begin
        next_seen <= next && !enter && !rst && (dbg_state == ST_SHOW);
    end

    // Monitor: a SHOW display is presented on entry to SHOW and after each
    // accepted `next`; a launch is presented whenever enc_load is high.
    always @(negedge clk) begin
        if (!rst) begin
            if (dbg_state == ST_SHOW && (prev_state != ST_SHOW || next_seen)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL show_unexpected: got %h, nothing expected", {led, digit, err, busy});
                end else begin
                    if ({led, digit, err, busy} !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL show_display: got led=%h digit=%h err=%b busy=%b, expected led=%h digit=%h err=%b busy=%b",
                                 led, digit, err, busy, exp_q[0][13:6], exp_q[0][5:2], exp_q[0][1], exp_q[0][0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (enc_load) begin
                n_cmp++;
                if (exp_val_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL load_unexpected: got enc_value=%h, no launch expected", enc_value);
                end else begin
                    if (enc_value !== exp_val_q[0]) begin
                        n_bad++;
                        $display("FAIL load_value: got %h expected %h", enc_value, exp_val_q[0]);
                    end
                    void'(exp_val_q.pop_front());
                end
            end
        end
        prev_state <= dbg_state;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // VB encoding: 7-bit groups, least significant first, bit 7 set on every
    // byte except the final one.
    task automatic vb_model(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        model_q.delete();
        do begin
            model_q.push_back({(r >> 7) != 0, r[6:0]});
            r = r >> 7;
        end while (r != 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_enter(input logic [7:0] b);
        @(negedge clk);
        sw    = b;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic pulse_next();
        @(negedge clk);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
    endtask

    task automatic enter_value(input logic [31:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) exp_val_q.push_back(v);
            pulse_enter(v[i*8 +: 8]);
            if (i == 2) begin
                check("collect_digit", 32'(digit), 2);
                check("collect_led_echo", 32'(led), 32'(v[23:16]));
            end
        end
    endtask

    task automatic leave_show();
        if (in_show) begin
            pulse_enter(8'h00);
            check("restart_state", 32'(dbg_state), 32'(ST_COLLECT));
            check("restart_err", 32'(err), 0);
            in_show = 1'b0;
        end
    endtask

    // mode 0: normal encode, 1: six bytes without last, 2: encoder silent.
    task automatic do_run(input logic [31:0] v, input int mode, input int ready_delay, input int n_next);
        logic [7:0] bytes[$];
        logic [7:0] cap[$];
        bit         hold_ok;
        bit         got;
        bit         err_e;
        int         si;

        leave_show();
        bytes.delete();
        cap.delete();
        if (mode == 0) begin
            vb_model(v);
            bytes = model_q;
        end else if (mode == 1) begin
            for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < bytes.size() && i < MAX_BYTES; i++) cap.push_back(bytes[i]);
        err_e = (mode != 0);

        enc_ready = (ready_delay == 0);
        enter_value(v);

        // Now in the first LAUNCH cycle.
        if (ready_delay > 0) begin
            hold_ok = 1'b1;
            for (int d = 0; d < ready_delay; d++) begin
                if (enc_load !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
                if (d < ready_delay - 1) tick(1);
            end
            check("launch_hold", 32'(hold_ok), 1);
            enc_ready = 1'b1;
            tick(1);
        end
        check("load_pulse", 32'(enc_load), 1);
        check("busy_launch", 32'(busy), 1);
        tick(1);
        check("load_single", 32'(enc_load), 0);
        check("busy_wait", 32'(busy), 1);

        exp_q.push_back({(cap.size() > 0) ? cap[0] : 8'h00, 4'd0, err_e, 1'b0});

        for (int i = 0; i < bytes.size(); i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            enc_valid = 1'b1;
            enc_byte  = bytes[i];
            enc_last  = (mode == 0) && (i == bytes.size() - 1);
            @(negedge clk);
            enc_valid = 1'b0;
            enc_last  = 1'b0;
        end

        if (mode == 2) begin
            tick(TIMEOUT - 2);
            check("watchdog_not_early", 32'(dbg_state), 32'(ST_WAIT));
        end

        got = 1'b0;
        for (int k = 0; k < TIMEOUT + 20 && !got; k++) begin
            if (dbg_state == ST_SHOW) got = 1'b1;
            else tick(1);
        end
        check("reach_show", 32'(got), 1);
        in_show = got;

        si = 0;
        for (int k = 0; k < n_next; k++) begin
            if (cap.size() > 0) begin
                si = (si + 1) % cap.size();
                exp_q.push_back({cap[si], 4'(si), err_e, 1'b0});
            end else begin
                exp_q.push_back({8'h00, 4'd0, err_e, 1'b0});
            end
            pulse_next();
        end
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; sw = 8'h00; enter = 1'b0; next = 1'b0;
        enc_ready = 1'b1; enc_valid = 1'b0; enc_byte = 8'h00; enc_last = 1'b0;
        tick(3);
        check("rst_state", 32'(dbg_state), 32'(ST_COLLECT));
        check("rst_enc_load", 32'(enc_load), 0);
        check("rst_enc_value", enc_value, 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_digit", 32'(digit), 0);
        rst = 1'b0;
        tick(2);

        // Directed runs from the bring-up plan.
        do_run(32'h0000007F, 0, 0, 2);
        do_run(32'd300, 0, 0, 2);

        // enter and next together in SHOW: enter wins.
        @(negedge clk);
        enter = 1'b1; next = 1'b1;
        @(negedge clk);
        enter = 1'b0; next = 1'b0;
        check("enter_wins_state", 32'(dbg_state), 32'(ST_COLLECT));
        check("enter_wins_err", 32'(err), 0);
        in_show = 1'b0;

        do_run($urandom, 0, 10, 1);      // encoder not ready for 10 cycles
        do_run($urandom, 1, 0, 5);       // overflow, next x5 wraps to buf[0]
        do_run($urandom, 2, 0, 2);       // timeout, next ignored

        // Reset while the encoder is mid-stream.
        leave_show();
        enc_ready = 1'b1;
        enter_value(32'h12345678);
        tick(1);
        enc_valid = 1'b1; enc_byte = 8'hF8; tick(1);
        enc_byte = 8'hAC; tick(1);
        enc_valid = 1'b0;
        rst = 1'b1; tick(1); rst = 1'b0;
        check("midrst_state", 32'(dbg_state), 32'(ST_COLLECT));
        check("midrst_busy", 32'(busy), 0);
        check("midrst_value", enc_value, 0);
        check("midrst_digit", 32'(digit), 0);
        enc_valid = 1'b1; enc_last = 1'b1; enc_byte = 8'h55; tick(1);
        enc_valid = 1'b0; enc_last = 1'b0; tick(1);
        check("late_byte_state", 32'(dbg_state), 32'(ST_COLLECT));
        check("late_byte_digit", 32'(digit), 0);
        // Partial entry then reset: the next value must start at the MSB.
        pulse_enter(8'hAA);
        pulse_enter(8'hBB);
        rst = 1'b1; tick(1); rst = 1'b0;
        do_run(32'hC0FFEE01, 0, 0, 3);

        // Randomised runs.
        for (int r = 0; r < 25; r++) begin
            int mode;
            mode = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 11) == 0) ? 2 : 0);
            do_run($urandom >> $urandom_range(0, 31), mode, $urandom_range(0, 3), $urandom_range(0, 6));
        end

        tick(3);
        check("show_queue_drained", 32'(exp_q.size()), 0);
        check("load_queue_drained", 32'(exp_val_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
